relu_vec_seq: RTL and testbench

- Sequencer that applies the element-wise ReLU bound (negative → 0, non-negative passes unchanged) across one vector register.
- Fetches source words from a vector register-file read port, runs LANES parallel relu_bound instances, and writes results to the destination register through a write port with byte enables.
- Started by the vector decode/issue stage. Owns both register-file ports while busy.

---
 rtl/relu_vec_seq.sv | 188 ++++++++++++++++++
 tb/tb_relu_vec_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_vec_seq.sv
// relu_vec_seq: applies element-wise ReLU across one vector register, streaming words from
// the register-file read port through LANES parallel lanes to the byte-enabled write port.
module relu_vec_seq #(
    parameter int unsigned EW            = 8,
    parameter int unsigned LANES         = 4,
    parameter int unsigned WORDS_PER_REG = 4,
    parameter int unsigned AW            = 8
) (
    input  logic                                 clk,
    input  logic                                 n_reset,
    input  logic                                 start_i,
    input  logic [$clog2(LANES*WORDS_PER_REG):0] vl_i,
    input  logic [4:0]                           vs_i,
    input  logic [4:0]                           vd_i,
    input  logic                                 hold_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 rd_en_o,
    output logic [AW-1:0]                        rd_addr_o,
    input  logic [EW*LANES-1:0]                  rd_data_i,
    output logic                                 wr_en_o,
    output logic [AW-1:0]                        wr_addr_o,
    output logic [EW*LANES-1:0]                  wr_data_o,
    output logic [EW*LANES/8-1:0]                wr_be_o
);

    localparam int unsigned VLW = $clog2(LANES*WORDS_PER_REG) + 1;
    localparam int unsigned DW  = EW * LANES;
    localparam int unsigned NB  = DW / 8;
    localparam int unsigned IW  = (WORDS_PER_REG > 1) ? $clog2(WORDS_PER_REG) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

    state_e         state_q, state_d;

    logic [4:0]     vs_q, vd_q;
    logic [VLW-1:0] vl_q;
    logic [IW-1:0]  rd_idx_q;
    logic [31:0]    nwords;
    logic           last_rd;
    logic           stall;

    logic           s1_valid_q;
    logic           s1_last_q;
    logic [IW-1:0]  s1_idx_q;
    logic           skid_valid_q;
    logic [DW-1:0]  skid_q;
    logic [DW-1:0]  s1_data;
    logic [DW-1:0]  lane_out;
    logic [NB-1:0]  s1_be;
    logic [AW-1:0]  s1_wr_addr;

    logic           wr_valid_q;
    logic           wr_last_q;
    logic [AW-1:0]  wr_addr_q;
    logic [DW-1:0]  wr_data_q;
    logic [NB-1:0]  wr_be_q;

    assign nwords  = (32'(vl_q) + LANES - 32'd1) / LANES;
    assign last_rd = (32'(rd_idx_q) == nwords - 32'd1);
    assign stall   = hold_i && ((state_q == StRun) || (state_q == StDrain));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = (vl_i != '0) ? StRun : StFin;
                end
            end
            StRun: begin
                if (rd_en_o && last_rd) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (wr_en_o && wr_last_q) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        busy_o  = (state_q == StRun) || (state_q == StDrain);
        done_o  = (state_q == StFin);
        rd_en_o = (state_q == StRun) && !hold_i;
    end

    // ---------------------------------------------------------------- command and read counter
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            vs_q     <= '0;
            vd_q     <= '0;
            vl_q     <= '0;
            rd_idx_q <= '0;
        end else if ((state_q == StIdle) && start_i && (vl_i != '0)) begin
            vs_q     <= vs_i;
            vd_q     <= vd_i;
            vl_q     <= vl_i;
            rd_idx_q <= '0;
        end else if (rd_en_o) begin
            rd_idx_q <= rd_idx_q + IW'(1);
        end
    end

    assign rd_addr_o = AW'(vs_q) * AW'(WORDS_PER_REG) + AW'(rd_idx_q);

    // ---------------------------------------------------------------- stage 1: lanes and enables
    // Data returned during a hold is parked in the skid register and replayed on release.
    assign s1_data = skid_valid_q ? skid_q : rd_data_i;

    always_comb begin
        lane_out = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (!s1_data[EW*i + EW - 1]) begin
                lane_out[EW*i +: EW] = {1'b0, s1_data[EW*i +: EW-1]};
            end
        end
    end

    always_comb begin
        s1_be = '0;
        for (int b = 0; b < int'(NB); b++) begin
            s1_be[b] = (32'(s1_idx_q) * LANES + (32'(b) * 32'd8) / EW) < 32'(vl_q);
        end
    end

    assign s1_wr_addr = AW'(vd_q) * AW'(WORDS_PER_REG) + AW'(s1_idx_q);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_idx_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else if (!stall) begin
            s1_valid_q   <= rd_en_o;
            s1_last_q    <= rd_en_o && last_rd;
            s1_idx_q     <= rd_idx_q;
            skid_valid_q <= 1'b0;
        end else if (s1_valid_q && !skid_valid_q) begin
            skid_q       <= rd_data_i;
            skid_valid_q <= 1'b1;
        end
    end

    // ---------------------------------------------------------------- stage 2: write registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_valid_q <= 1'b0;
            wr_last_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_be_q    <= '0;
        end else if (!stall) begin
            wr_valid_q <= s1_valid_q;
            wr_last_q  <= s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                wr_addr_q <= s1_wr_addr;
                wr_data_q <= lane_out;
                wr_be_q   <= s1_be;
            end
        end
    end

    assign wr_en_o   = wr_valid_q && !stall;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign wr_be_o   = wr_be_q;

endmodule

// File: tb/tb_relu_vec_seq.sv
// tb_relu_vec_seq: scoreboard bench for relu_vec_seq; a register-file model answers reads and
// expected reads/writes are queued when each command is driven.
module tb_relu_vec_seq;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        start_i;
    logic [4:0]  vl_i;
    logic [4:0]  vs_i;
    logic [4:0]  vd_i;
    logic        hold_i;
    logic        busy_o;
    logic        done_o;
    logic        rd_en_o;
    logic [7:0]  rd_addr_o;
    logic [31:0] rd_data_i;
    logic        wr_en_o;
    logic [7:0]  wr_addr_o;
    logic [31:0] wr_data_o;
    logic [3:0]  wr_be_o;

    relu_vec_seq dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .start_i   (start_i),
        .vl_i      (vl_i),
        .vs_i      (vs_i),
        .vd_i      (vd_i),
        .hold_i    (hold_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .rd_en_o   (rd_en_o),
        .rd_addr_o (rd_addr_o),
        .rd_data_i (rd_data_i),
        .wr_en_o   (wr_en_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o),
        .wr_be_o   (wr_be_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        int         cyc;
    } rd_exp_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        int          cyc;
    } wr_exp_t;

    typedef struct {
        logic [4:0] vs;
        logic [4:0] vd;
        logic [4:0] vl;
        int         nw;
        logic [3:0] last_be;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          wr_count = 0;
    int          done_cnt = 0;
    logic [3:0]  last_be  = '0;
    logic [7:0]  last_wa  = '0;
    logic [31:0] mem [256];
    rd_exp_t     rdq [$];
    wr_exp_t     wrq [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Register-file model: valid data only the cycle after a read, garbage otherwise.
    always @(posedge clk) rd_data_i <= rd_en_o ? mem[rd_addr_o] : $urandom;

    always @(negedge clk) begin : monitor
        rd_exp_t re;
        wr_exp_t we;
        if (rd_en_o) begin
            if (rdq.size() == 0) begin
                check("rd_spurious", 64'(rd_en_o), 64'(0));
            end else begin
                re = rdq.pop_front();
                check("rd_addr", 64'(rd_addr_o), 64'(re.addr));
                check("rd_cycle", 64'(cyc), 64'(re.cyc));
            end
        end
        if (wr_en_o) begin
            wr_count++;
            last_be = wr_be_o;
            last_wa = wr_addr_o;
            if (wrq.size() == 0) begin
                check("wr_spurious", 64'(wr_en_o), 64'(0));
            end else begin
                we = wrq.pop_front();
                check("wr_addr", 64'(wr_addr_o), 64'(we.addr));
                check("wr_data", 64'(wr_data_o), 64'(we.data));
                check("wr_be", 64'(wr_be_o), 64'(we.be));
                check("wr_cycle", 64'(cyc), 64'(we.cyc));
            end
        end
        if (done_o) done_cnt++;
    end

    // Expected traffic; a hold of hl cycles starting where read hw would go shifts later events.
    task automatic push_cmd(input logic [4:0] vs, input logic [4:0] vd, input logic [4:0] vl,
                            input int c0, input int hw, input int hl);
        int nw;
        nw = (int'(vl) + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            rd_exp_t     r;
            wr_exp_t     x;
            logic [31:0] src;
            int          v;
            r.addr = 8'(int'(vs) * 4 + w);
            r.cyc  = c0 + 1 + w + ((w >= hw) ? hl : 0);
            src    = mem[r.addr];
            x.addr = 8'(int'(vd) * 4 + w);
            x.cyc  = c0 + 3 + w + ((w + 2 >= hw) ? hl : 0);
            for (int i = 0; i < 4; i++) begin
                v = int'($signed(src[8*i +: 8]));
                x.data[8*i +: 8] = 8'((v > 0) ? v : 0);
                x.be[i] = (w * 4 + i) < int'(vl);
            end
            rdq.push_back(r);
            wrq.push_back(x);
        end
    endtask

    task automatic start_cmd(input logic [4:0] vs, input logic [4:0] vd, input logic [4:0] vl,
                             input int hw, input int hl, output int c0);
        @(posedge clk);
        #1;
        start_i = 1'b1;
        vs_i    = vs;
        vd_i    = vd;
        vl_i    = vl;
        c0      = cyc;
        push_cmd(vs, vd, vl, c0, hw, hl);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int dc);
        dc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_o) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) begin
            check("done_seen", 64'(done_o), 64'(1));
        end else begin
            @(negedge clk);
            check("done_pulse_width", 64'(done_o), 64'(0));
            check("busy_after_done", 64'(busy_o), 64'(0));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy_o), 64'(0));
        check({tag, "_done"}, 64'(done_o), 64'(0));
        check({tag, "_rd_en"}, 64'(rd_en_o), 64'(0));
        check({tag, "_rd_addr"}, 64'(rd_addr_o), 64'(0));
        check({tag, "_wr_en"}, 64'(wr_en_o), 64'(0));
        check({tag, "_wr_addr"}, 64'(wr_addr_o), 64'(0));
        check({tag, "_wr_data"}, 64'(wr_data_o), 64'(0));
        check({tag, "_wr_be"}, 64'(wr_be_o), 64'(0));
    endtask

    initial begin
        vec_t tbl [6];
        int   c0;
        int   dc;
        int   wc0;
        int   dn0;

        tbl[0] = '{vs: 5'd1,  vd: 5'd2,  vl: 5'd16, nw: 4, last_be: 4'hF};
        tbl[1] = '{vs: 5'd0,  vd: 5'd3,  vl: 5'd6,  nw: 2, last_be: 4'h3};
        tbl[2] = '{vs: 5'd5,  vd: 5'd6,  vl: 5'd1,  nw: 1, last_be: 4'h1};
        tbl[3] = '{vs: 5'd7,  vd: 5'd8,  vl: 5'd13, nw: 4, last_be: 4'h1};
        tbl[4] = '{vs: 5'd9,  vd: 5'd10, vl: 5'd4,  nw: 1, last_be: 4'hF};
        tbl[5] = '{vs: 5'd11, vd: 5'd12, vl: 5'd11, nw: 3, last_be: 4'h7};

        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 4; i < 8; i++) mem[i] = 32'h80FF007F;
        for (int j = 0; j < 64; j++) begin
            mem[64 + j] = {8'(4*j + 3), 8'(4*j + 2), 8'(4*j + 1), 8'(4*j)};
        end

        n_reset = 1'b1;
        start_i = 1'b0;
        hold_i  = 1'b0;
        vl_i    = '0;
        vs_i    = '0;
        vd_i    = '0;
        #2 n_reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 n_reset = 1'b1;

        // Table-driven commands with exact cycle timing.
        for (int t = 0; t < 6; t++) begin
            wc0 = wr_count;
            start_cmd(tbl[t].vs, tbl[t].vd, tbl[t].vl, 99, 0, c0);
            wait_done(60, dc);
            check("done_cycle", 64'(dc), 64'(c0 + tbl[t].nw + 3));
            check("write_count", 64'(wr_count - wc0), 64'(tbl[t].nw));
            check("last_be", 64'(last_be), 64'(tbl[t].last_be));
        end

        // vl=0: immediate completion, no port activity, then a normal command.
        wc0 = wr_count;
        start_cmd(5'd4, 5'd5, 5'd0, 99, 0, c0);
        wait_done(10, dc);
        check("vl0_done_cycle", 64'(dc), 64'(c0 + 1));
        check("vl0_no_writes", 64'(wr_count - wc0), 64'(0));
        start_cmd(5'd13, 5'd14, 5'd9, 99, 0, c0);
        wait_done(60, dc);
        check("after_vl0_done_cycle", 64'(dc), 64'(c0 + 6));

        // Hold for two cycles right after the second read.
        wc0 = wr_count;
        start_cmd(5'd2, 5'd4, 5'd16, 2, 2, c0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 hold_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("hold_rd_en", 64'(rd_en_o), 64'(0));
            check("hold_wr_en", 64'(wr_en_o), 64'(0));
            check("hold_busy", 64'(busy_o), 64'(1));
            @(posedge clk);
            #1;
        end
        hold_i = 1'b0;
        wait_done(60, dc);
        check("hold_done_cycle", 64'(dc), 64'(c0 + 9));
        check("hold_write_count", 64'(wr_count - wc0), 64'(4));

        // Reset in the middle of RUN abandons the operation.
        start_cmd(5'd3, 5'd5, 5'd16, 99, 0, c0);
        wrq.delete();
        while (rdq.size() > 2) void'(rdq.pop_back());
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 n_reset = 1'b0;
        @(negedge clk);
        check_all_zero("midrun");
        repeat (2) @(posedge clk);
        #1 n_reset = 1'b1;
        dn0 = done_cnt;
        wc0 = wr_count;
        repeat (8) @(negedge clk);
        check("no_done_after_reset", 64'(done_cnt), 64'(dn0));
        check("no_write_after_reset", 64'(wr_count), 64'(wc0));
        check("idle_after_reset", 64'(busy_o), 64'(0));
        start_cmd(5'd3, 5'd5, 5'd16, 99, 0, c0);
        wait_done(60, dc);
        check("post_reset_done_cycle", 64'(dc), 64'(c0 + 7));

        // start_i while busy and while in FIN is ignored.
        wc0 = wr_count;
        dn0 = done_cnt;
        start_cmd(5'd4, 5'd7, 5'd8, 99, 0, c0);
        start_i = 1'b1;
        vs_i    = 5'd20;
        vd_i    = 5'd21;
        vl_i    = 5'd16;
        @(posedge clk);
        #1 start_i = 1'b0;
        while (cyc < c0 + 5) begin
            @(posedge clk);
            #1;
        end
        start_i = 1'b1;
        @(negedge clk);
        check("fin_done", 64'(done_o), 64'(1));
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (6) @(negedge clk);
        check("ignored_start_busy", 64'(busy_o), 64'(0));
        check("ignored_start_writes", 64'(wr_count - wc0), 64'(2));
        check("ignored_start_done_cnt", 64'(done_cnt - dn0), 64'(1));
        check("ignored_start_last_addr", 64'(last_wa), 64'(8'd29));

        // Every byte value -128..127 through the lanes.
        for (int r = 16; r < 32; r++) begin
            start_cmd(5'(r), 5'(r - 16), 5'd16, 99, 0, c0);
            wait_done(60, dc);
            check("sweep_done_cycle", 64'(dc), 64'(c0 + 7));
        end

        repeat (3) @(negedge clk);
        check("rd_queue_drained", 64'(rdq.size()), 64'(0));
        check("wr_queue_drained", 64'(wrq.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
